// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock,
// LSB first, through a DIGIT-bit ripple slice with a registered inter-cycle carry.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [DIGIT-1:0] slice_sum;
  logic [DIGIT:0]   slice_c;
  logic             accept, last;

  // slice_c[DIGIT-1] is the carry into the operand MSB on the final slice
  always_comb begin
    slice_c    = '0;
    slice_sum  = '0;
    slice_c[0] = carry;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      slice_sum[i]  = a_reg[i] ^ b_reg[i] ^ slice_c[i];
      slice_c[i+1]  = (a_reg[i] & b_reg[i]) | (slice_c[i] & (a_reg[i] ^ b_reg[i]));
    end
  end

  // Sum digits enter at the MSB end so the result is aligned after N shifts
  assign acc_next = WIDTH'({slice_sum, acc} >> DIGIT);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      c     <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_reg <= in1;
        b_reg <= sub ? ~in2 : in2;
        carry <= sub ? ~cin : cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_reg <= a_reg >> DIGIT;
        b_reg <= b_reg >> DIGIT;
        carry <= slice_c[DIGIT];
        cnt   <= cnt + CNT_W'(1);
        acc   <= acc_next;
        if (last) begin
          s   <= acc_next;
          c   <= slice_c[DIGIT];
          ovf <= slice_c[DIGIT-1] ^ slice_c[DIGIT];
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: 8/1 directed handshake cases, 8/4 random
// operands and a 4/4 exhaustive sweep against an independent arithmetic model.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, cin0, sub0, busy0, done0, c0, ovf0;
  logic [7:0] a0, b0, s0;
  logic       start1, cin1, sub1, busy1, done1, c1, ovf1;
  logic [7:0] a1, b1, s1;
  logic       start2, cin2, sub2, busy2, done2, c2, ovf2;
  logic [3:0] a2, b2, s2;

  exp_t q0[$], q1[$], q2[$];
  int unsigned nchk  = 0;
  int unsigned npass = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .in1(a0), .in2(b0), .cin(cin0), .sub(sub0),
    .busy(busy0), .done(done0), .s(s0), .c(c0), .ovf(ovf0));
  serial_adder #(.WIDTH(8), .DIGIT(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in1(a1), .in2(b1), .cin(cin1), .sub(sub1),
    .busy(busy1), .done(done1), .s(s1), .c(c1), .ovf(ovf1));
  serial_adder #(.WIDTH(4), .DIGIT(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in1(a2), .in2(b2), .cin(cin2), .sub(sub2),
    .busy(busy2), .done(done2), .s(s2), .c(c2), .ovf(ovf2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input int unsigned w, input logic [7:0] a,
                                 input logic [7:0] b, input logic ci, input logic sb);
    exp_t       r;
    logic [8:0] full;
    logic [7:0] mask, am, bm;
    logic       cc;
    mask  = 8'((9'd1 << w) - 9'd1);
    am    = a & mask;
    bm    = (sb ? ~b : b) & mask;
    cc    = sb ? ~ci : ci;
    full  = {1'b0, am} + {1'b0, bm} + {8'd0, cc};
    r.s   = full[7:0] & mask;
    r.c   = full[w];
    r.ovf = (am[w-1] == bm[w-1]) && (r.s[w-1] != am[w-1]);
    return r;
  endfunction

  task automatic cmp0(input string tag);
    exp_t e;
    chk({tag, "_pending"}, 32'(q0.size()), 32'd1);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk({tag, "_s"}, 32'(s0), 32'(e.s));
      chk({tag, "_c"}, 32'(c0), 32'(e.c));
      chk({tag, "_ovf"}, 32'(ovf0), 32'(e.ovf));
    end
  endtask

  task automatic wait_done0(input string tag, input int unsigned exp_busy);
    int unsigned nb  = 0;
    bit          got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done0) begin
        got = 1'b1;
        break;
      end
      if (busy0) nb++;
      @(posedge clk); #1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_busy_cycles"}, nb, exp_busy);
    if (got) begin
      chk({tag, "_busy_in_done"}, 32'(busy0), 32'd0);
      cmp0(tag);
    end
  endtask

  task automatic drive0(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb);
    start0 = 1'b1; a0 = a; b0 = b; cin0 = ci; sub0 = sb;
    q0.push_back(model(8, a, b, ci, sb));
  endtask

  task automatic run0(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic sb);
    drive0(a, b, ci, sb);
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_done0(tag, 8);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done0), 32'd0);
  endtask

  task automatic run_n(input int unsigned which, input string tag, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input logic sb);
    int unsigned exp_busy = (which == 1) ? 2 : 1;
    int unsigned nb  = 0;
    bit          got = 1'b0;
    exp_t        e;
    if (which == 1) begin
      start1 = 1'b1; a1 = a; b1 = b; cin1 = ci; sub1 = sb;
      q1.push_back(model(8, a, b, ci, sb));
    end else begin
      start2 = 1'b1; a2 = a[3:0]; b2 = b[3:0]; cin2 = ci; sub2 = sb;
      q2.push_back(model(4, a, b, ci, sb));
    end
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((which == 1) ? done1 : done2) begin
        got = 1'b1;
        break;
      end
      if ((which == 1) ? busy1 : busy2) nb++;
      @(posedge clk); #1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_busy_cycles"}, nb, exp_busy);
    if (got) begin
      if (which == 1) begin
        chk({tag, "_pending"}, 32'(q1.size()), 32'd1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk({tag, "_s"}, 32'(s1), 32'(e.s));
          chk({tag, "_c"}, 32'(c1), 32'(e.c));
          chk({tag, "_ovf"}, 32'(ovf1), 32'(e.ovf));
        end
      end else begin
        chk({tag, "_pending"}, 32'(q2.size()), 32'd1);
        if (q2.size() > 0) begin
          e = q2.pop_front();
          chk({tag, "_s"}, 32'({4'd0, s2}), 32'(e.s));
          chk({tag, "_c"}, 32'(c2), 32'(e.c));
          chk({tag, "_ovf"}, 32'(ovf2), 32'(e.ovf));
        end
      end
    end
  endtask

  initial begin
    int unsigned extra_done;
    rst = 1'b1;
    start0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_done", 32'(done0), 32'd0);
    chk("reset_s", 32'(s0), 32'd0);
    chk("reset_c", 32'(c0), 32'd0);
    chk("reset_ovf", 32'(ovf0), 32'd0);
    chk("reset_s_w4", 32'(s2), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run0("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    run0("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
    run0("add_12_34_c", 8'h12, 8'h34, 1'b1, 1'b0);
    run0("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1);
    run0("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1);

    // start pulsed mid-RUN with other operands must be ignored
    drive0(8'h21, 8'h42, 1'b0, 1'b0);
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("midrun_s_held", 32'(s0), 32'h7F);
    start0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF; cin0 = 1'b1; sub0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; a0 = 8'h00; b0 = 8'h00;
    wait_done0("midrun", 5);
    extra_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done0) extra_done++;
    end
    chk("midrun_single_done", extra_done, 32'd0);

    // start held in the DONE cycle chains directly into RUN
    drive0(8'h10, 8'h20, 1'b0, 1'b0);
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    chk("chain_done1", 32'(done0), 32'd1);
    cmp0("chain_op1");
    drive0(8'hC0, 8'h50, 1'b1, 1'b1);
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("chain_no_idle", 32'(busy0), 32'd1);
    wait_done0("chain_op2", 8);
    @(posedge clk); #1;
    chk("chain_done_pulse", 32'(done0), 32'd0);

    // asynchronous reset during RUN cycle 3
    drive0(8'h33, 8'h44, 1'b0, 1'b0);
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_s", 32'(s0), 32'd0);
    chk("abort_c", 32'(c0), 32'd0);
    chk("abort_ovf", 32'(ovf0), 32'd0);
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    extra_done = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done0) extra_done++;
    end
    chk("abort_no_done", extra_done, 32'd0);
    run0("after_abort", 8'hA5, 8'h5A, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_n(1, "w8d4_rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    run_n(1, "w8d4_ovf", 8'h7F, 8'h7F, 1'b1, 1'b0);
    run_n(1, "w8d4_sub", 8'h00, 8'hFF, 1'b1, 1'b1);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int m = 0; m < 4; m++) begin
          run_n(2, "w4d4_sweep", 8'(a), 8'(b), m[0], m[1]);
        end
      end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
